// File: rtl/fp_norm_round_stage.sv
// Add/sub FP datapath stage 4: normalize, round and pack an IEEE-754 single in two register stages.
// Optional directed rounding modes are enabled by defining FP_ROUND_MODE_EN.
module fp_norm_round_stage #(
  parameter int DataSize     = 32,
  parameter int FractionSize = 23,
  parameter int MantissaSize = FractionSize + 1,
  parameter int RoundingSize = MantissaSize + 3,
  parameter int ExponentSize = 8,
  parameter int ExpBias      = 127
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RoundingSize-1:0] AdderResult,
  input  logic                    EffCarry,
  input  logic [4:0]              NormShifts,
  input  logic [ExponentSize-1:0] ResultExponent,
  input  logic                    ResultSign,
`ifdef FP_ROUND_MODE_EN
  input  logic [1:0]              RoundMode,
`endif
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [DataSize-1:0]     Result,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Inexact
);

  localparam int ExpIntSize = ExponentSize + 2;
  localparam int ExpInf     = 2 * ExpBias + 1;
  localparam int MaxNormExp = 2 * ExpBias;

  logic s1_valid_q;
  logic s2_valid_q;
  logic s2_adv;
  logic s1_load;
  logic in_fire;

  assign s2_adv  = ~s2_valid_q | OutReady;
  assign s1_load = ~s1_valid_q | s2_adv;
  assign in_fire = InValid & s1_load;
  assign InReady = s1_load;

  // ---------------- S1: normalize ----------------
  logic [RoundingSize-1:0] norm_mant;
  logic [ExpIntSize-1:0]   norm_exp;
  logic                    norm_zero;
  logic                    norm_uflow;

  always_comb begin
    norm_mant = AdderResult << NormShifts;
    norm_exp  = ExpIntSize'(ResultExponent) - ExpIntSize'(NormShifts);
    if (EffCarry) begin
      norm_mant = {1'b1, AdderResult[RoundingSize-1:2], AdderResult[1] | AdderResult[0]};
      norm_exp  = ExpIntSize'(ResultExponent) + ExpIntSize'(1);
    end
  end

  assign norm_zero  = ~EffCarry & (AdderResult == '0);
  // Exponent is two's complement here; zero or negative means the result is below the normal range.
  assign norm_uflow = ~norm_zero & (norm_exp[ExpIntSize-1] | (norm_exp == '0));

  logic                    s1_sign_q;
  logic                    s1_zero_q;
  logic                    s1_uflow_q;
  logic [ExpIntSize-1:0]   s1_exp_q;
  logic [RoundingSize-1:0] s1_mant_q;
  logic [1:0]              rmode;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_uflow_q <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= InValid;
      end
      if (in_fire) begin
        s1_sign_q  <= ResultSign;
        s1_zero_q  <= norm_zero;
        s1_uflow_q <= norm_uflow;
        s1_exp_q   <= norm_exp;
        s1_mant_q  <= norm_mant;
      end
    end
  end

`ifdef FP_ROUND_MODE_EN
  logic [1:0] s1_mode_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_mode_q <= 2'b00;
    end else if (in_fire) begin
      s1_mode_q <= RoundMode;
    end
  end

  assign rmode = s1_mode_q;
`else
  assign rmode = 2'b00;
`endif

  // ---------------- S2: round and pack ----------------
  logic                    rnd_lsb;
  logic                    rnd_g;
  logic                    rnd_r;
  logic                    rnd_s;
  logic                    rnd_grs;
  logic                    rnd_inc;
  logic                    rnd_carry;
  logic [FractionSize-1:0] rnd_frac;
  logic [ExpIntSize-1:0]   rnd_exp;
  logic                    sat_max;

  assign rnd_lsb = s1_mant_q[3];
  assign rnd_g   = s1_mant_q[2];
  assign rnd_r   = s1_mant_q[1];
  assign rnd_s   = s1_mant_q[0];
  assign rnd_grs = rnd_g | rnd_r | rnd_s;

  always_comb begin
    rnd_inc = 1'b0;
    case (rmode)
      2'b00:   rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      2'b01:   rnd_inc = 1'b0;
      2'b10:   rnd_inc = ~s1_sign_q & rnd_grs;
      default: rnd_inc = s1_sign_q & rnd_grs;
    endcase
  end

  // An all-ones mantissa that increments wraps the fraction to zero and bumps the exponent.
  assign rnd_carry = rnd_inc & (&s1_mant_q[RoundingSize-1:3]);
  assign rnd_frac  = s1_mant_q[RoundingSize-2:3] + FractionSize'(rnd_inc);
  assign rnd_exp   = s1_exp_q + ExpIntSize'(rnd_carry);
  assign sat_max   = (rmode == 2'b01) | ((rmode == 2'b10) & s1_sign_q) |
                     ((rmode == 2'b11) & ~s1_sign_q);

  logic [DataSize-1:0] result_d;
  logic                ovf_d;
  logic                unf_d;
  logic                inx_d;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inx_d    = 1'b0;
    if (s1_zero_q) begin
      result_d = '0;
    end else if (s1_uflow_q) begin
      result_d = {s1_sign_q, {(DataSize-1){1'b0}}};
      unf_d    = 1'b1;
      inx_d    = 1'b1;
    end else if (~rnd_exp[ExpIntSize-1] & (rnd_exp >= ExpIntSize'(ExpInf))) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      if (sat_max) begin
        result_d = {s1_sign_q, ExponentSize'(MaxNormExp), {FractionSize{1'b1}}};
      end else begin
        result_d = {s1_sign_q, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
      end
    end else begin
      result_d = {s1_sign_q, rnd_exp[ExponentSize-1:0], rnd_frac};
      inx_d    = rnd_grs;
    end
  end

  logic [DataSize-1:0] result_q;
  logic                ovf_q;
  logic                unf_q;
  logic                inx_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inx_q    <= inx_d;
      end
    end
  end

  assign OutValid  = s2_valid_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Inexact   = inx_q;

endmodule

// File: doc/fp_norm_round_stage.md
Name: fp_norm_round_stage

Overview:
- Pipelined stage 4 of the add/sub floating-point datapath.
- Consumes the stage-3 outputs (adder result, effective carry, leading-zero count, selected exponent) together with the result sign.
- Normalizes, rounds (round-to-nearest-even by default), detects overflow/underflow and packs an IEEE-754 single-precision word.
- Two internal register stages (normalize, round/pack) with valid/ready handshake on both sides.

Parameters:
- DataSize, 32, packed result width
- FractionSize, 23, fraction bits
- MantissaSize, FractionSize+1, mantissa width including hidden bit
- RoundingSize, MantissaSize+3, mantissa plus guard, round and sticky bits
- ExponentSize, 8, exponent width
- ExpBias, 127, exponent bias; max normal exponent is 2*ExpBias

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  upstream presents a valid operand set
- InReady  out  1  stage can accept; transfer when InValid & InReady
- AdderResult  in  RoundingSize  magnitude from stage 3: [26:3] mantissa, [2] G, [1] R, [0] S
- EffCarry  in  1  addition carry-out; result needs a 1-bit right shift
- NormShifts  in  5  leading zeros of AdderResult[26:3], range 0..24
- ResultExponent  in  ExponentSize  biased exponent before normalization
- ResultSign  in  1  sign of the result
- OutValid  out  1  Result and flags valid
- OutReady  in  1  downstream accepts; transfer when OutValid & OutReady
- Result  out  DataSize  packed {sign, exponent, fraction}
- Overflow  out  1  result saturated to infinity
- Underflow  out  1  result flushed to zero (nonzero input)
- Inexact  out  1  any of G/R/S nonzero after normalization

Behaviour:
- Reset (async, Reset_n=0):
  - both stage valid bits clear, so OutValid=0.
  - Result, Overflow, Underflow and Inexact are 0.
  - InReady=1 as soon as Reset_n releases.
  - A reset asserted mid-operation discards all in-flight data.
- Handshake and pipelining:
  - Each stage register loads when it is empty or the next stage is advancing.
  - InReady = ~S1valid | S2advance; S2advance = ~S2valid | OutReady.
  - Latency is 2 cycles from input transfer to OutValid; throughput is 1 per cycle with OutReady held high.
  - While OutValid=1 and OutReady=0, Result and all flags hold stable.
  - Order is always preserved.
  - With both stages full and OutReady=0, InReady=0.
- S1 (normalize); exponent arithmetic is 10-bit signed internally:
  - EffCarry=1: mantissa = {1, AdderResult[26:1]}, sticky |= AdderResult[0], exponent + 1.
  - EffCarry=0 and AdderResult==0: exact zero; Result={ResultSign... forced 0}, i.e. +0 output, no flags.
  - EffCarry=0 otherwise: shift left by NormShifts, exponent - NormShifts.
  - If that exponent <= 0: flush to signed zero, Underflow=1, Inexact=1. Denormals are not produced.
- S2 (round/pack):
  - Round-to-nearest-even: increment when G & (R | S | LSB).
  - Rounding carry out of bit 23: mantissa becomes 1.0 and exponent + 1.
  - Final exponent >= 255: Result = {sign, 8'hFF, 23'h0}, Overflow=1, Inexact=1.
  - Otherwise Result = {sign, exp[7:0], mant[22:0]}.
- Flag latch: flags are registered with Result and valid only while OutValid=1.

Optional Feature:
- Macro: FP_ROUND_MODE_EN.
- When defined:
  - Adds input port RoundMode [1:0], captured with the operands: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
  - RTZ never increments.
  - +inf mode increments when ~sign & (G|R|S); -inf mode increments when sign & (G|R|S).
  - On overflow, RTZ and the directed mode opposite the sign return max-normal {sign, 8'hFE, 23'h7FFFFF} instead of infinity. Overflow=1 in every mode.
- When undefined: no port; RNE only.

Test Plan:
- 1.0+1.0: AdderResult=27'h0000000, EffCarry=1, NormShifts=0, ResultExponent=8'h7F, sign 0 -> 2 cycles later Result=32'h40000000, all flags 0.
- Cancellation: AdderResult=27'h0400000, EffCarry=0, NormShifts=4, ResultExponent=8'h82 -> Result=32'h3F000000, flags 0.
- Rounding:
  - Tie to odd LSB: AdderResult=27'h400000C, NormShifts=0, exp 8'h7F -> Result=32'h3F800002, Inexact=1.
  - Rounding carry-out: AdderResult=27'h7FFFFFE -> Result=32'h40000000, Inexact=1.
- Overflow and underflow:
  - EffCarry=1, AdderResult=0, exp 8'hFE, sign 1 -> Result=32'hFF800000, Overflow=1.
  - AdderResult=27'h0000008, NormShifts=23, exp 8'h10 -> Result=32'h00000000, Underflow=1.
- Backpressure: stream 3 transfers with OutReady=0.
  - InReady drops after 2 accepted; Result is stable across 3 stalled cycles.
  - Raising OutReady drains all 3 in order on consecutive cycles.
  - Reset_n pulsed mid-stall clears OutValid immediately.
